// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encodings, byte-enable base patterns and request record for the load/store unit.
// Pure declarations: no latency, no flow control.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t ST_IDLE = 2'd0;
   localparam lsu_state_t ST_REQ  = 2'd1;
   localparam lsu_state_t ST_RESP = 2'd2;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication and enables, load lane select with sign/zero extension.
// Purely combinational, zero latency; no flow control of its own.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        zext;

   assign zext   = funct3_i[2];
   assign lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
   // Halfword lane follows addr[1] only, so an odd address folds onto its containing half.
   assign lane_h = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      wdata_o = wdata_i;
      be_o    = BE_WORD;
      rdata_o = rdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = BE_BYTE << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{~zext & lane_b[7]}}, lane_b};
         end
         2'b01: begin
            be_o    = BE_HALF << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{~zext & lane_h[15]}}, lane_h};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory LSU: one req/ack bus transaction per load/store; min 3 cycles, +1 per ack wait; stall_o holds decode.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of silently aligning them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        done_o,
   output logic        err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   lsu_state_t    state_q, state_d;
   lsu_req_t      req_q, req_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ok_q, ok_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          req_any, req_bad, misalign, tmo, in_req;
   logic [31:0]   al_wdata, al_rdata;
   logic [3:0]    al_be;

   assign req_any = mem_rd_i | mem_wr_i;
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign req_bad = (mem_rd_i & mem_wr_i) | ~f3_legal(funct3_i) | misalign;
   assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   lsu_align u_align (
      .funct3_i  (req_q.funct3),
      .addr_lo_i (req_q.addr[1:0]),
      .wdata_i   (req_q.wdata),
      .rdata_i   (bus_rdata_i),
      .wdata_o   (al_wdata),
      .be_o      (al_be),
      .rdata_o   (al_rdata)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      ok_d    = ok_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req_any) begin
               req_d.we     = mem_wr_i;
               req_d.funct3 = funct3_i;
               req_d.addr   = addr_i;
               req_d.wdata  = wdata_i;
               ok_d         = 1'b0;
               // Rejected requests still pass through RESP so the error pulse has one fixed slot.
               state_d      = req_bad ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_err_i) begin
               ok_d    = 1'b0;
               state_d = ST_RESP;
            end else if (bus_ack_i) begin
               ok_d    = 1'b1;
               if (!req_q.we) rdata_d = al_rdata;
               state_d = ST_RESP;
            end else if (tmo) begin
               ok_d    = 1'b0;
               state_d = ST_RESP;
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         rdata_q <= rdata_d;
      end
   end

   assign in_req      = (state_q == ST_REQ);
   assign stall_o     = in_req | ((state_q == ST_IDLE) & req_any);
   assign done_o      = (state_q == ST_RESP) & ok_q;
   assign err_o       = (state_q == ST_RESP) & ~ok_q;
   assign bus_req_o   = in_req;
   assign bus_we_o    = in_req & req_q.we;
   assign bus_addr_o  = in_req ? {req_q.addr[31:2], 2'b00} : '0;
   assign bus_wdata_o = (in_req & req_q.we) ? al_wdata : '0;
   assign bus_be_o    = in_req ? al_be : '0;
   assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (TIMEOUT_CYCLES = 4): completions are scored against a queue of expected outcomes.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int TMO     = 4;
   localparam int K_ACK   = 0;
   localparam int K_ERR   = 1;
   localparam int K_BOTH  = 2;
   localparam int K_NONE  = 3;
   localparam int K_NOBUS = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_rd_i, mem_wr_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o, done_o, err_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i, bus_err_i;
   logic [31:0] bus_rdata_i;

   typedef struct {
      logic        ok;
      logic [31:0] rd;
      int          start;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc_n = 0;
   logic [31:0] last_rd = 32'h0;

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .mem_rd_i    (mem_rd_i),
      .mem_wr_i    (mem_wr_i),
      .funct3_i    (funct3_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rdata_o     (rdata_o),
      .stall_o     (stall_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_be_o    (bus_be_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i),
      .bus_err_i   (bus_err_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_n <= cyc_n + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   // Completion monitor: every done/err pulse must match the oldest outstanding expectation.
   always @(negedge clk_i) begin
      if (!rst_i && (done_o || err_o)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_completion", 32'(done_o | err_o), 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("done_pulse", 32'(done_o), 32'(mon_e.ok));
            chk("err_pulse", 32'(err_o), 32'(!mon_e.ok));
            chk("rdata_at_completion", rdata_o, mon_e.rd);
            chk("latency", 32'(cyc_n - mon_e.start), 32'(mon_e.lat));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after RESP, so calls chain back-to-back.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input int kind, input logic [31:0] brd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd);
      exp_t e;
      int   cyc, nreq, exp_nreq;
      bit   fin;
      mem_rd_i = rd;
      mem_wr_i = wr;
      funct3_i = f3;
      addr_i   = a;
      wdata_i  = wd;
      e.ok     = (kind == K_ACK);
      e.rd     = exp_rd;
      e.start  = cyc_n;
      case (kind)
         K_NONE:  begin e.lat = TMO + 1;   exp_nreq = TMO;       end
         K_NOBUS: begin e.lat = 1;         exp_nreq = 0;         end
         default: begin e.lat = waits + 2; exp_nreq = waits + 1; end
      endcase
      sb_q.push_back(e);
      cyc  = 0;
      nreq = 0;
      fin  = 0;
      while (!fin && cyc < 40) begin
         bus_ack_i   = 1'b0;
         bus_err_i   = 1'b0;
         bus_rdata_i = 32'hDEAD_BEEF;
         if (bus_req_o) begin
            nreq++;
            chk("bus_addr", bus_addr_o, {a[31:2], 2'b00});
            chk("bus_be", 32'(bus_be_o), 32'(exp_be));
            chk("bus_we", 32'(bus_we_o), 32'(wr));
            if (wr) chk("bus_wdata", bus_wdata_o, exp_wd);
            if (kind <= K_BOTH && nreq == waits + 1) begin
               bus_ack_i   = (kind != K_ERR);
               bus_err_i   = (kind != K_ACK);
               bus_rdata_i = brd;
            end
         end
         @(negedge clk_i);
         if (done_o || err_o) begin
            fin = 1;
            chk("stall_release", 32'(stall_o), 32'd0);
         end else if (kind != K_NOBUS) begin
            chk("stall_hold", 32'(stall_o), 32'd1);
         end
         @(posedge clk_i);
         #1;
         cyc++;
      end
      mem_rd_i  = 1'b0;
      mem_wr_i  = 1'b0;
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      chk("completed_in_budget", 32'(fin), 32'd1);
      chk("bus_req_cycles", 32'(nreq), 32'(exp_nreq));
      if (kind == K_ACK && !wr) last_rd = exp_rd;
   endtask

   initial begin
      rst_i       = 1'b1;
      mem_rd_i    = 1'b0;
      mem_wr_i    = 1'b0;
      funct3_i    = 3'b000;
      addr_i      = 32'h0;
      wdata_i     = 32'h0;
      bus_ack_i   = 1'b0;
      bus_err_i   = 1'b0;
      bus_rdata_i = 32'h0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_ctrl", 32'({stall_o, done_o, err_o, bus_req_o, bus_we_o}), 32'd0);
      chk("rst_bus_addr", bus_addr_o, 32'h0);
      chk("rst_bus_wdata", bus_wdata_o, 32'h0);
      chk("rst_bus_be", 32'(bus_be_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("idle_no_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;

      // sb 0x1003, two wait cycles
      access(1'b0, 1'b1, F3_B,  32'h0000_1003, 32'h0000_00AB, 2, K_ACK, 32'h0, 4'b1000, 32'hABAB_ABAB, last_rd);
      // lb then lbu on lane 2
      access(1'b1, 1'b0, F3_B,  32'h0000_2002, 32'h0, 0, K_ACK, 32'h0080_FF00, 4'b0100, 32'h0, 32'hFFFF_FF80);
      access(1'b1, 1'b0, F3_BU, 32'h0000_2002, 32'h0, 0, K_ACK, 32'h0080_FF00, 4'b0100, 32'h0, 32'h0000_0080);
`ifdef LSU_MISALIGN_TRAP_EN
      access(1'b1, 1'b0, F3_H,  32'h0000_3001, 32'h0, 0, K_NOBUS, 32'h0, 4'b0000, 32'h0, last_rd);
`else
      access(1'b1, 1'b0, F3_H,  32'h0000_3001, 32'h0, 0, K_ACK, 32'h1234_8765, 4'b0011, 32'h0, 32'hFFFF_8765);
`endif
      // lw that never gets a response, then ack+err together, then plain bus error
      access(1'b1, 1'b0, F3_W,  32'h0000_4000, 32'h0, 0, K_NONE, 32'h0, 4'b1111, 32'h0, last_rd);
      access(1'b1, 1'b0, F3_W,  32'h0000_4004, 32'h0, 1, K_BOTH, 32'hCAFE_F00D, 4'b1111, 32'h0, last_rd);
      access(1'b1, 1'b0, F3_W,  32'h0000_4008, 32'h0, 0, K_ERR, 32'h1111_1111, 4'b1111, 32'h0, last_rd);
      access(1'b1, 1'b0, F3_W,  32'h0000_400C, 32'h0, 1, K_ACK, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);
      access(1'b0, 1'b1, F3_H,  32'h0000_5002, 32'h1234_BEEF, 0, K_ACK, 32'h0, 4'b1100, 32'hBEEF_BEEF, last_rd);
      access(1'b1, 1'b0, F3_HU, 32'h0000_6002, 32'h0, 0, K_ACK, 32'h8001_0000, 4'b1100, 32'h0, 32'h0000_8001);
      access(1'b1, 1'b0, F3_H,  32'h0000_6002, 32'h0, 3, K_ACK, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
      access(1'b1, 1'b0, F3_B,  32'h0000_7001, 32'h0, 0, K_ACK, 32'h0000_7F00, 4'b0010, 32'h0, 32'h0000_007F);
      access(1'b0, 1'b1, F3_W,  32'h0000_7104, 32'hA5A5_0F0F, 0, K_ACK, 32'h0, 4'b1111, 32'hA5A5_0F0F, last_rd);
      // rejected without bus access: illegal funct3, and load+store together
      access(1'b1, 1'b0, 3'b011, 32'h0000_7200, 32'h0, 0, K_NOBUS, 32'h0, 4'b0000, 32'h0, last_rd);
      access(1'b1, 1'b1, F3_W,   32'h0000_7300, 32'h0, 0, K_NOBUS, 32'h0, 4'b0000, 32'h0, last_rd);

      // stray response while idle
      bus_ack_i   = 1'b1;
      bus_err_i   = 1'b1;
      bus_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      chk("idle_ack_outputs", 32'({done_o, err_o, stall_o, bus_req_o}), 32'd0);
      @(posedge clk_i);
      #1;
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      @(negedge clk_i);
      chk("idle_ack_no_resp", 32'({done_o, err_o}), 32'd0);
      chk("idle_ack_rdata_hold", rdata_o, last_rd);
      @(posedge clk_i);
      #1;

      // reset while a lw sits in REQ, ack arriving one cycle late
      mem_rd_i = 1'b1;
      funct3_i = F3_W;
      addr_i   = 32'h0000_8000;
      @(posedge clk_i);
      #1;
      chk("mid_req_busreq", 32'(bus_req_o), 32'd1);
      rst_i    = 1'b1;
      mem_rd_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("rst_drops_busreq", 32'(bus_req_o), 32'd0);
      rst_i       = 1'b0;
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h5555_AAAA;
      @(negedge clk_i);
      chk("rst_no_completion", 32'({done_o, err_o, stall_o}), 32'd0);
      chk("rst_clears_rdata", rdata_o, 32'h0);
      @(posedge clk_i);
      #1;
      bus_ack_i = 1'b0;
      @(negedge clk_i);
      chk("late_ack_ignored", 32'({done_o, err_o, bus_req_o}), 32'd0);
      chk("late_ack_rdata", rdata_o, 32'h0);
      last_rd = 32'h0;
      @(posedge clk_i);
      #1;
      access(1'b0, 1'b1, F3_W, 32'h0000_9000, 32'h0102_0304, 0, K_ACK, 32'h0, 4'b1111, 32'h0102_0304, last_rd);

      repeat (3) @(posedge clk_i);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
